// File: rtl/arb_pkg.sv
// arb_pkg: shared widths, FSM state type and one-hot to index helper for the round-robin arbiter
package arb_pkg;
    localparam int N_REQ = 8;
    localparam int ID_W  = 3;
    localparam int CNT_W = 8;

    typedef enum logic {IDLE, OWNED} state_t;

    function automatic logic [ID_W-1:0] oh2id(input logic [N_REQ-1:0] oh);
        oh2id = '0;
        for (int i = 0; i < N_REQ; i++)
            if (oh[i]) oh2id = oh2id | ID_W'(i);
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker
//   req  : request vector
//   ptr  : highest-priority index; scan runs upward from here, wrapping 7->0
//   pick : one-hot winner (zero when no request)
//   any  : at least one request present
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] pick,
    output logic             any
);
    always_comb begin
        pick = '0;
        for (int i = 0; i < N_REQ; i++) begin
            logic [ID_W-1:0] idx;
            idx = ptr + ID_W'(i);
            if (req[idx] && pick == '0) pick[idx] = 1'b1;
        end
    end

    assign any = |req;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: 8-way round-robin arbiter with ownership hold and optional hold-time limit
//   clk, rst     : clock, asynchronous active-high reset
//   req          : request vector, held high by a requester until done
//   grant        : registered one-hot grant, zero when idle
//   grant_valid  : registered, high iff grant non-zero
//   grant_id     : registered binary index of the granted bit, zero when idle
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic [ID_W-1:0]  grant_id
);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(MAX_HOLD - 1);

    state_t             state, state_n;
    logic [N_REQ-1:0]   grant_n, pick;
    logic [ID_W-1:0]    ptr, ptr_n, pick_ptr;
    logic [CNT_W-1:0]   hold_cnt, hold_n;
    logic               any, timeout, rel;

    assign timeout  = (MAX_HOLD != 0) && (hold_cnt == LIM);
    assign rel      = (state == OWNED) && (!req[grant_id] || timeout);
    // On release the scan starts just past the owner, so an evicted owner
    // that still requests ranks last and is re-granted only if alone.
    assign pick_ptr = (state == OWNED) ? grant_id + ID_W'(1) : ptr;

    rr_pick u_pick (
        .req  (req),
        .ptr  (pick_ptr),
        .pick (pick),
        .any  (any)
    );

    always_comb begin
        state_n = state;
        grant_n = grant;
        ptr_n   = ptr;
        hold_n  = (hold_cnt == '1) ? hold_cnt : hold_cnt + CNT_W'(1);
        if (state == IDLE || rel) begin
            if (rel) ptr_n = pick_ptr;
            state_n = any ? OWNED : IDLE;
            grant_n = pick;
            hold_n  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            ptr         <= '0;
            hold_cnt    <= '0;
        end else begin
            state       <= state_n;
            grant       <= grant_n;
            grant_valid <= |grant_n;
            grant_id    <= oh2id(grant_n);
            ptr         <= ptr_n;
            hold_cnt    <= hold_n;
        end
    end
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed and randomized checks of rr_arbiter with MAX_HOLD=4 and MAX_HOLD=16
module tb_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic [7:0] g4, g16;
    logic       v4, v16;
    logic [2:0] id4, id16;
    int         tests = 0;
    int         fails = 0;

    rr_arbiter #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst(rst), .req(req),
        .grant(g4), .grant_valid(v4), .grant_id(id4)
    );

    rr_arbiter #(.MAX_HOLD(16)) dut16 (
        .clk(clk), .rst(rst), .req(req),
        .grant(g16), .grant_valid(v16), .grant_id(id16)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int        run4, run16, worst;
        int        waitc[8];
        logic [7:0] p4, p16, req_e;
        logic      ok, bad4, bad16;

        rst = 1'b1;
        req = '0;
        step();
        check("rst_grant", g4, 8'h00);
        check("rst_valid", v4, 1'b0);
        check("rst_id", id4, 3'd0);
        check("rst_grant16", g16, 8'h00);

        rst = 1'b0;
        req = 8'hFF;
        step();
        check("first_grant", g4, 8'h01);
        check("first_id", id4, 3'd0);
        check("first_valid", v4, 1'b1);
        req = 8'hFE;
        step();
        check("handoff_grant", g4, 8'h02);
        check("handoff_id", id4, 3'd1);
        check("handoff_grant16", g16, 8'h02);
        req = 8'h00;
        step();
        check("idle_grant", g4, 8'h00);
        check("idle_valid", v4, 1'b0);
        check("idle_id", id4, 3'd0);

        do_reset();
        req = 8'h81;
        for (int i = 0; i < 16; i++) begin
            step();
            check("alt_g4", g4, ((i / 4) % 2 == 0) ? 8'h01 : 8'h80);
            check("alt_g16", g16, 8'h01);
        end

        do_reset();
        req = 8'h20;
        for (int i = 0; i < 12; i++) begin
            step();
            check("sole_grant", g4, 8'h20);
            check("sole_valid", v4, 1'b1);
            check("sole_hold", dut4.hold_cnt, i % 4);
        end

        do_reset();
        req = 8'h80;
        step();
        check("own7_grant", g4, 8'h80);
        check("own7_id", id4, 3'd7);
        req = 8'h41;
        step();
        check("wrap_grant", g4, 8'h01);
        check("wrap_id", id4, 3'd0);

        do_reset();
        req = 8'h08;
        step();
        check("pre_rst_grant", g4, 8'h08);
        #3 rst = 1'b1;
        #1;
        check("async_rst_grant", g4, 8'h00);
        check("async_rst_valid", v4, 1'b0);
        check("async_rst_id", id4, 3'd0);
        rst = 1'b0;
        req = 8'h0C;
        step();
        check("post_rst_grant", g4, 8'h04);

        do_reset();
        run4  = 0;
        run16 = 0;
        foreach (waitc[i]) waitc[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 8; i++) begin
                if (g16[i] && $urandom_range(7) == 0) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(3) == 0) req[i] = 1'b1;
            end
            p4    = g4;
            p16   = g16;
            req_e = req;
            step();
            ok = $onehot0(g4) && $onehot0(g16)
                 && (v4 == (g4 != 0)) && (v16 == (g16 != 0))
                 && ((g4 == 0) ? (id4 == 0) : g4[id4])
                 && ((g16 == 0) ? (id16 == 0) : g16[id16]);
            check("rnd_consistent", ok, 1'b1);
            bad4  = 1'b0;
            bad16 = 1'b0;
            if (g16 != 0 && g16 == p16) begin
                if (run16 == 16) begin
                    bad16 = (req_e & ~p16) != 0;
                    run16 = 1;
                end else run16++;
            end else run16 = (g16 != 0) ? 1 : 0;
            if (g4 != 0 && g4 == p4) begin
                if (run4 == 4) begin
                    bad4 = (req_e & ~p4) != 0;
                    run4 = 1;
                end else run4++;
            end else run4 = (g4 != 0) ? 1 : 0;
            check("rnd_hold16", bad16, 1'b0);
            check("rnd_hold4", bad4, 1'b0);
            worst = 0;
            for (int i = 0; i < 8; i++) begin
                waitc[i] = (req[i] && !g16[i]) ? waitc[i] + 1 : 0;
                if (waitc[i] > worst) worst = waitc[i];
            end
            check("rnd_wait", worst <= 128, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16, maximum consecutive grant cycles per owner (range 0..255; 0 = unlimited).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  8  request vector; bit i high = requester i wants the shared resource, held high until done.
REQ-005 grant  output  8  registered one-hot grant (all-zero when idle).
REQ-006 grant_valid  output  1  registered; high iff grant is non-zero.
REQ-007 grant_id  output  3  registered binary index of granted bit; 0 when idle.

Function
REQ-008 The block SHALL be a two-state FSM: IDLE (no owner) and OWNED (one owner).
REQ-009 IDLE: if req != 0 at an edge, the block SHALL enter OWNED with grant set to the winner at that edge (1-cycle latency req->grant); otherwise stay IDLE.
REQ-010 Winner: first set bit of req scanning upward from index ptr, wrapping 7->0.
REQ-011 ptr SHALL be a 3-bit register, reset 0, updated only on release to (owner+1) mod 8.
REQ-012 OWNED: while req[owner]=1 and no timeout, grant SHALL hold unchanged; other requests SHALL NOT preempt.
REQ-013 Release: at an edge where req[owner]=0, or where hold_cnt = MAX_HOLD-1 with MAX_HOLD != 0 (timeout).
REQ-014 On release, the next grant SHALL be computed in the same edge using ptr = owner+1 (zero-bubble handoff); if no request remains, go IDLE with grant=0.
REQ-015 On timeout, the evicted owner, if still requesting, is eligible at lowest priority; if it is the sole requester it SHALL be re-granted with hold_cnt restarted.
REQ-016 hold_cnt SHALL be an 8-bit counter, cleared on every new grant (including re-grant), incremented each OWNED cycle, saturating at 255; with MAX_HOLD=0 timeout never fires.
REQ-017 MAX_HOLD=1 SHALL give at most one cycle per grant, rotating every cycle among active requesters.
REQ-018 grant SHALL always be one-hot or zero; grant_valid and grant_id SHALL be consistent with grant in the same cycle.
REQ-019 ptr wrap: owner 7 released -> ptr 0.

Reset
REQ-020 Asserting rst SHALL immediately (asynchronously) force grant=0, grant_valid=0, grant_id=0, ptr=0, hold_cnt=0, state IDLE, including mid-grant.
REQ-021 First edge after rst deasserts SHALL arbitrate from ptr=0 per REQ-009.

Structure
REQ-022 Shared package arb_pkg SHALL hold N_REQ=8, ID_W=3, CNT_W=8 and the FSM state enum (IDLE, OWNED).
REQ-023 Combinational sub-module rr_pick SHALL take req[7:0] and ptr[2:0] and return one-hot pick[7:0] and any; rr_arbiter instantiates it once.
REQ-024 No combinational path from req to any output.

Verification
REQ-025 Reset, req=8'hFF -> cycle 1 grant=8'h01, grant_id=0; drop req[0] -> next cycle grant=8'h02.
REQ-026 MAX_HOLD=4, req=8'h81 held constant -> grant alternates 8'h01 (4 cycles), 8'h80 (4 cycles), repeating with no idle cycle.
REQ-027 Only req[5] held, MAX_HOLD=4 -> grant=8'h20 continuously, hold_cnt restarts 0 every 4 cycles, grant_valid never drops.
REQ-028 Owner 7 releases with req=8'h41 -> next grant=8'h01 (ptr wrapped to 0), not 8'h40.
REQ-029 rst asserted between clock edges while grant=8'h08 -> grant=0 before next edge; after release with req=8'h0C -> grant=8'h04.
REQ-030 Random req for 10k cycles, MAX_HOLD=16: assert grant one-hot/zero, no owner exceeds 16 consecutive cycles, every continuously-held request granted within 8*16 cycles.
